// File: rtl/alu_cmd_issuer_if.sv
// Command, ALU and result bundle between a command source, alu_cmd_issuer and the ALU.
// The issuer uses the slave modport; the environment (sequencer + ALU) uses master.
interface alu_cmd_issuer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst;
    logic [1:0] cmd_srca;
    logic [1:0] cmd_srcb;
    logic [7:0] cmd_imm;

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       alu_sign;
    logic       alu_over;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_flags;

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_out, alu_carry, alu_sign, alu_over,
        output res_valid, res_data, res_flags,
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_out, alu_carry, alu_sign, alu_over,
        input  res_valid, res_data, res_flags,
        output res_ready
    );
endinterface

// File: rtl/alu_cmd_issuer.sv
// Issues register-file commands to an 8-bit combinational ALU and returns the result.
// Define ALU_ISSUER_FLAGS_EN to capture {over, sign, carry} into res_flags.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for a command
// EXEC  | operands on the ALU for one cycle, write-back at the end
// RESP  | res_valid=1, holding result until res_ready
module alu_cmd_issuer (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_issuer_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state, state_next;
    logic [7:0] regs [4];
    logic [2:0] op_q;
    logic [1:0] dst_q;
    logic [1:0] srca_q;
    logic [1:0] srcb_q;
    logic [7:0] res_data_q;
    logic       accept;

    assign accept = (state == IDLE) && bus.cmd_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.alu_a     = 8'h00;
        bus.alu_b     = 8'h00;
        bus.alu_op    = 3'b000;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = bus.cmd_load ? RESP : EXEC;
                end
            end
            EXEC: begin
                bus.alu_a  = regs[srca_q];
                bus.alu_b  = regs[srcb_q];
                bus.alu_op = op_q;
                state_next = RESP;
            end
            RESP: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Reset wins over any write-back scheduled for the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= 8'h00;
            end
            op_q       <= 3'b000;
            dst_q      <= 2'd0;
            srca_q     <= 2'd0;
            srcb_q     <= 2'd0;
            res_data_q <= 8'h00;
        end else begin
            if (accept) begin
                op_q   <= bus.cmd_op;
                dst_q  <= bus.cmd_dst;
                srca_q <= bus.cmd_srca;
                srcb_q <= bus.cmd_srcb;
                if (bus.cmd_load) begin
                    regs[bus.cmd_dst] <= bus.cmd_imm;
                    res_data_q        <= bus.cmd_imm;
                end
            end
            if (state == EXEC) begin
                regs[dst_q] <= bus.alu_out;
                res_data_q  <= bus.alu_out;
            end
        end
    end

    assign bus.res_data = res_data_q;

`ifdef ALU_ISSUER_FLAGS_EN
    logic [2:0] res_flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_flags_q <= 3'b000;
        end else if (accept && bus.cmd_load) begin
            res_flags_q <= 3'b000;
        end else if (state == EXEC) begin
            res_flags_q <= {bus.alu_over, bus.alu_sign, bus.alu_carry};
        end
    end

    assign bus.res_flags = res_flags_q;
`else
    logic unused_flags;

    assign unused_flags  = &{1'b0, bus.alu_over, bus.alu_sign, bus.alu_carry};
    assign bus.res_flags = 3'b000;
`endif
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed scenarios plus random commands
// checked against a register-file/ALU reference model.
module tb_alu_cmd_issuer;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    logic [7:0] mregs [4];

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate-style stand-in for the ALU instance.
    always_comb begin
        bus.alu_out   = 8'h00;
        bus.alu_carry = 1'b0;
        bus.alu_over  = 1'b0;
        case (bus.alu_op)
            3'b000: begin
                {bus.alu_carry, bus.alu_out} = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_over = (bus.alu_a[7] == bus.alu_b[7]) && (bus.alu_out[7] != bus.alu_a[7]);
            end
            3'b001: begin
                bus.alu_out   = bus.alu_a - bus.alu_b;
                bus.alu_carry = bus.alu_a < bus.alu_b;
                bus.alu_over  = (bus.alu_a[7] != bus.alu_b[7]) && (bus.alu_out[7] != bus.alu_a[7]);
            end
            3'b010: bus.alu_out = bus.alu_a & bus.alu_b;
            3'b011: bus.alu_out = bus.alu_a | bus.alu_b;
            3'b100: bus.alu_out = bus.alu_a ^ bus.alu_b;
            3'b101: bus.alu_out = ~bus.alu_a;
            3'b110: begin
                bus.alu_out   = {bus.alu_a[6:0], 1'b0};
                bus.alu_carry = bus.alu_a[7];
            end
            default: begin
                bus.alu_out  = bus.alu_a[7] ? (~bus.alu_a + 8'h01) : bus.alu_a;
                bus.alu_over = (bus.alu_a == 8'h80);
            end
        endcase
        bus.alu_sign = bus.alu_out[7];
    end

    // Reference: {over, sign, carry, result} from integer arithmetic.
    function automatic logic [10:0] ref_alu(input int op, input int a, input int b);
        int   r, sa, sb, sr;
        logic c, v;
        logic [7:0] o;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            0: begin r = a + b; c = (r > 255); sr = sa + sb; v = (sr > 127) || (sr < -128); end
            1: begin r = a - b; c = (a < b);   sr = sa - sb; v = (sr > 127) || (sr < -128); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 255 - a;
            6: begin r = a * 2; c = (a >= 128); end
            default: begin r = (sa < 0) ? -sa : sa; v = (sa == -128); end
        endcase
        o = 8'(r & 255);
        return {v, o[7], c, o};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
    endtask

    // Runs one command from IDLE to IDLE, holding res_ready low for hold cycles in RESP.
    task automatic issue(input bit ld, input logic [2:0] op, input logic [1:0] d,
                         input logic [1:0] sa, input logic [1:0] sb,
                         input logic [7:0] imm, input int hold);
        logic [10:0] e;
        logic [2:0]  ef;
        chk("idle_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = ld;
        bus.cmd_op    = op;
        bus.cmd_dst   = d;
        bus.cmd_srca  = sa;
        bus.cmd_srcb  = sb;
        bus.cmd_imm   = imm;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_imm   = 8'(~imm);
        if (ld) begin
            e = {3'b000, imm};
        end else begin
            chk("exec_res_valid", {7'd0, bus.res_valid}, 8'd0);
            chk("exec_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
            chk("exec_alu_a", bus.alu_a, mregs[sa]);
            chk("exec_alu_b", bus.alu_b, mregs[sb]);
            chk("exec_alu_op", {5'd0, bus.alu_op}, {5'd0, op});
            e = ref_alu(int'(op), int'(mregs[sa]), int'(mregs[sb]));
            tick();
        end
`ifdef ALU_ISSUER_FLAGS_EN
        ef = e[10:8];
`else
        ef = 3'b000;
`endif
        mregs[d] = e[7:0];
        for (int k = 0; k <= hold; k++) begin
            chk("resp_res_valid", {7'd0, bus.res_valid}, 8'd1);
            chk("resp_res_data", bus.res_data, e[7:0]);
            chk("resp_res_flags", {5'd0, bus.res_flags}, {5'd0, ef});
            chk("resp_cmd_ready", {7'd0, bus.cmd_ready}, 8'd0);
            chk("resp_alu_a", bus.alu_a, 8'h00);
            if (k < hold) tick();
        end
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("post_res_valid", {7'd0, bus.res_valid}, 8'd0);
    endtask

    task automatic read_reg(input logic [1:0] r);
        issue(1'b0, 3'b011, r, r, r, 8'h00, 0);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_dst   = 2'd0;
        bus.cmd_srca  = 2'd0;
        bus.cmd_srcb  = 2'd0;
        bus.cmd_imm   = 8'h00;
        bus.res_ready = 1'b0;
        @(negedge clk);
        do_reset();

        chk("rst_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);
        chk("rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("rst_res_data", bus.res_data, 8'h00);
        chk("rst_res_flags", {5'd0, bus.res_flags}, 8'd0);
        chk("rst_alu_a", bus.alu_a, 8'h00);
        chk("rst_alu_b", bus.alu_b, 8'h00);
        chk("rst_alu_op", {5'd0, bus.alu_op}, 8'd0);
        for (int i = 0; i < 4; i++) read_reg(2'(i));

        issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h05, 0);
        issue(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h03, 0);
        issue(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 0);
        chk("add_model", mregs[2], 8'h08);
        read_reg(2'd2);

        issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h80, 0);
        issue(1'b1, 3'b000, 2'd1, 2'd0, 2'd0, 8'h01, 0);
        issue(1'b0, 3'b001, 2'd2, 2'd0, 2'd1, 8'h00, 0);
        issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'hFF, 0);
        issue(1'b0, 3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 0);

        issue(1'b1, 3'b000, 2'd3, 2'd0, 2'd0, 8'h40, 0);
        issue(1'b0, 3'b110, 2'd3, 2'd3, 2'd0, 8'h00, 0);
        read_reg(2'd3);

        issue(1'b0, 3'b100, 2'd1, 2'd3, 2'd0, 8'h00, 5);
        issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h5A, 5);

        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        chk("stray_ready_res_valid", {7'd0, bus.res_valid}, 8'd0);
        chk("stray_ready_cmd_ready", {7'd0, bus.cmd_ready}, 8'd1);

        for (int n = 0; n < 60; n++) begin
            issue(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                  int'($urandom_range(0, 2)));
        end

        issue(1'b1, 3'b000, 2'd2, 2'd0, 2'd0, 8'h11, 0);
        issue(1'b1, 3'b000, 2'd0, 2'd0, 2'd0, 8'h22, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_load  = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_dst   = 2'd2;
        bus.cmd_srca  = 2'd0;
        bus.cmd_srcb  = 2'd0;
        tick();
        bus.cmd_valid = 1'b0;
        chk("mid_exec_alu_a", bus.alu_a, 8'h22);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            chk("after_rst_res_valid", {7'd0, bus.res_valid}, 8'd0);
            chk("after_rst_res_data", bus.res_data, 8'h00);
            if (k < 2) tick();
        end
        read_reg(2'd2);
        read_reg(2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
